// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: width functions and the elaboration-time
// parameter legality check.
package fifo_pkg;

    // Read-side behaviour selected by the FWFT parameter.
    typedef enum logic {
        RD_REGISTERED = 1'b0,
        RD_SHOW_AHEAD = 1'b1
    } rd_mode_e;

    localparam int MIN_DEPTH = 2;

    function automatic int fifo_level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int fifo_ptr_w(input int max);
        return (max > 1) ? $clog2(max) : 1;
    endfunction

    function automatic bit fifo_params_ok(input int depth, input int af_thresh,
                                          input int ae_thresh);
        return (depth >= MIN_DEPTH) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

    function automatic rd_mode_e fifo_rd_mode(input int fwft);
        return (fwft != 0) ? RD_SHOW_AHEAD : RD_REGISTERED;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-MAX pointer for the FIFO storage array; wraps by explicit compare so any
// MAX >= 2 is supported, not only powers of two.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int MAX = 16,
    localparam int PW = fifo_ptr_w(MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(MAX - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, registered or show-ahead read, programmable
// almost-full/almost-empty thresholds, fill level, synchronous flush and sticky errors.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1,
    localparam int LW        = fifo_level_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    output logic                  wr_overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic                  rd_underflow,
    output logic [LW-1:0]         level
);

    localparam int       PW      = fifo_ptr_w(DEPTH);
    localparam rd_mode_e RD_MODE = fifo_rd_mode(FWFT);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    if (!fifo_params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_check
        $fatal(1, "sync_fifo: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;

    // Flags come straight from the registered level so they settle one cycle after
    // the push or pop that moved it.
    assign wr_full         = (level == DEPTH_L);
    assign rd_empty        = (level == '0);
    assign wr_almost_full  = (level >= AF_L);
    assign rd_almost_empty = (level <= AE_L);

    // A flush or reset cycle suppresses both sides so nothing half-completes.
    assign push = wr_en && !wr_full  && !clr && !rst;
    assign pop  = rd_en && !rd_empty && !clr && !rst;

    fifo_wrap_ptr #(.MAX(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (push),
        .ptr (wr_ptr)
    );

    fifo_wrap_ptr #(.MAX(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (pop),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags survive a flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else if (!clr) begin
            if (wr_en && wr_full) begin
                wr_overflow <= 1'b1;
            end
            if (rd_en && rd_empty) begin
                rd_underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    if (RD_MODE == RD_SHOW_AHEAD) begin : g_show_ahead
        // Head word is presented combinationally; zero while empty keeps the reset
        // value of rd_data well defined despite the unreset storage.
        assign rd_data  = rd_empty ? '0 : mem[rd_ptr];
        assign rd_valid = !rd_empty;
    end else begin : g_registered
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (clr) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= pop;
                if (pop) begin
                    rd_data_q <= mem[rd_ptr];
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a registered-read and a show-ahead instance share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic          full0, afull0, ovf0, vld0, empty0, aempty0, unf0;
    logic [DW-1:0] data0;
    logic [LW-1:0] level0;
    logic          full1, afull1, ovf1, vld1, empty1, aempty1, unf1;
    logic [DW-1:0] data1;
    logic [LW-1:0] level1;

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(full0), .wr_almost_full(afull0), .wr_overflow(ovf0),
        .rd_en(rd_en), .rd_data(data0), .rd_valid(vld0), .rd_empty(empty0),
        .rd_almost_empty(aempty0), .rd_underflow(unf0), .level(level0)
    );

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(full1), .wr_almost_full(afull1), .wr_overflow(ovf1),
        .rd_en(rd_en), .rd_data(data1), .rd_valid(vld1), .rd_empty(empty1),
        .rd_almost_empty(aempty1), .rd_underflow(unf1), .level(level1)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // Reference model: contents as a queue plus the registered-read output state.
    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    bit            m_rdv = 1'b0;
    logic [DW-1:0] m_rdd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    endtask

    task automatic model_update(input bit w, input bit r, input logic [DW-1:0] d,
                                input bit c, input bit rs);
        bit was_full;
        bit was_empty;
        if (rs) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rdv = 1'b0;
            m_rdd = '0;
        end else if (c) begin
            q.delete();
            m_rdv = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            if (r && !was_empty) begin
                m_rdd = q.pop_front();
                m_rdv = 1'b1;
            end else begin
                m_rdv = 1'b0;
            end
            if (w && !was_full) q.push_back(d);
        end
    endtask

    task automatic check_all();
        int            n;
        logic [DW-1:0] head;
        n    = q.size();
        head = (n != 0) ? q[0] : '0;
        chk("level",         32'(level0),  32'(n));
        chk("level_fwft",    32'(level1),  32'(n));
        chk("rd_empty",      32'(empty0),  32'(n == 0));
        chk("wr_full",       32'(full0),   32'(n == DEPTH));
        chk("almost_empty",  32'(aempty0), 32'(n <= AE));
        chk("almost_full",   32'(afull0),  32'(n >= AF));
        chk("wr_overflow",   32'(ovf0),    32'(m_ovf));
        chk("rd_underflow",  32'(unf0),    32'(m_unf));
        chk("rd_valid_reg",  32'(vld0),    32'(m_rdv));
        chk("rd_data_reg",   32'(data0),   32'(m_rdd));
        chk("rd_valid_fwft", 32'(vld1),    32'(n != 0));
        chk("rd_data_fwft",  32'(data1),   32'(head));
        chk("flags_fwft",    32'({full1, afull1, ovf1, empty1, aempty1, unf1}),
            32'({n == DEPTH, n >= AF, m_ovf, n == 0, n <= AE, m_unf}));
    endtask

    task automatic step(input bit w, input bit r, input logic [DW-1:0] d,
                        input bit c = 1'b0, input bit rs = 1'b0);
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        clr     = c;
        rst     = rs;
        @(posedge clk);
        model_update(w, r, d, c, rs);
        cyc++;
        #1;
        check_all();
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00);

        // Fill to full, then one overflowing write; drain in order
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 8'(i * 8'h11));
        step(1'b1, 1'b0, 8'h66);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Steady simultaneous write/read at level 2
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'hE0);
        step(1'b1, 1'b0, 8'hE1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(8'h80 + i));
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);

        // Underflow on empty with concurrent write; write still lands
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Show-ahead visibility one cycle after the write
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b1, 8'h00);

        // Flush at level 3 with sticky overflow set, then reset
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'hBB, 1'b1);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Full with simultaneous write and read
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
        step(1'b1, 1'b1, 8'hDD);
        step(1'b0, 1'b0, 8'h00);

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 8'($urandom),
                 $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
